// File: rtl/clause_row_scanner_pkg.sv
// clause_pkg: shared literal types and helpers for the clause datapath
package clause_pkg;
  localparam int LIT_WIDTH_DEF = 6;
  typedef enum logic [1:0] {EXACT = 2'd0, COMPL = 2'd1, EITHER = 2'd2} scan_mode_e;
  function automatic logic [LIT_WIDTH_DEF-1:0] lit_compl(input logic [LIT_WIDTH_DEF-1:0] l);
    return l ^ LIT_WIDTH_DEF'(1);
  endfunction
  function automatic logic lit_is_empty(input logic [LIT_WIDTH_DEF-1:0] l);
    return l[LIT_WIDTH_DEF-1:1] == '0;
  endfunction
endpackage

// File: rtl/clause_row_scanner_if.sv
// clause_row_scanner_if: load, start and result handshakes of the row scanner
interface clause_row_scanner_if import clause_pkg::*; #(
  parameter int COLS_PER_ROW = 4,
  parameter int LIT_WIDTH = LIT_WIDTH_DEF,
  parameter int NUM_ROWS = 16
);
  localparam int ROW_W = $clog2(NUM_ROWS);
  logic load_valid, load_ready;
  logic [ROW_W-1:0] load_addr;
  logic [COLS_PER_ROW*LIT_WIDTH-1:0] load_row;
  logic start_valid, start_ready;
  logic [LIT_WIDTH-1:0] start_literal;
  logic [1:0] start_mode;
  logic out_valid, out_ready, out_last, done;
  logic [ROW_W-1:0] out_row_idx;
  logic [COLS_PER_ROW-1:0] out_pos_mask, out_neg_mask;
  logic [ROW_W:0] match_count;
  modport master (
    output load_valid, load_addr, load_row, start_valid, start_literal, start_mode, out_ready,
    input load_ready, start_ready, out_valid, out_row_idx, out_pos_mask, out_neg_mask, out_last, done, match_count
  );
  modport slave (
    input load_valid, load_addr, load_row, start_valid, start_literal, start_mode, out_ready,
    output load_ready, start_ready, out_valid, out_row_idx, out_pos_mask, out_neg_mask, out_last, done, match_count
  );
endinterface

// File: rtl/clause_row_scanner_matcher.sv
// literal_row_matcher: per-slot exact/complement match of one row against target t
module literal_row_matcher import clause_pkg::*; #(
  parameter int COLS_PER_ROW = 4,
  parameter int LIT_WIDTH = LIT_WIDTH_DEF
) (
  input  logic [COLS_PER_ROW*LIT_WIDTH-1:0] row,
  input  logic [LIT_WIDTH-1:0] t,
  input  scan_mode_e mode,
  output logic [COLS_PER_ROW-1:0] pos_mask,
  output logic [COLS_PER_ROW-1:0] neg_mask
);
  logic pos_en, neg_en;
  assign pos_en = mode != COMPL && !lit_is_empty(t);
  assign neg_en = mode != EXACT && !lit_is_empty(t);
  for (genvar i = 0; i < COLS_PER_ROW; i++) begin : g_slot
    logic [LIT_WIDTH-1:0] lit;
    assign lit = row[i*LIT_WIDTH +: LIT_WIDTH];
    assign pos_mask[i] = pos_en && !lit_is_empty(lit) && lit == t;
    assign neg_mask[i] = neg_en && !lit_is_empty(lit) && lit == lit_compl(t);
  end
endmodule

// File: rtl/clause_row_scanner.sv
// clause_row_scanner: row store streamed through a two-stage literal match pipeline
module clause_row_scanner import clause_pkg::*; #(
  parameter int COLS_PER_ROW = 4,
  parameter int LIT_WIDTH = LIT_WIDTH_DEF,
  parameter int NUM_ROWS = 16
) (
  input logic clk,
  input logic rst,
  clause_row_scanner_if.slave bus
);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int RW = COLS_PER_ROW*LIT_WIDTH;
  localparam logic [ROW_W-1:0] LAST = ROW_W'(NUM_ROWS-1);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;
  state_e state, state_nx;
  logic [RW-1:0] rows [NUM_ROWS];
  logic [LIT_WIDTH-1:0] t_q;
  scan_mode_e mode_q;
  logic [ROW_W-1:0] cnt, s1_idx;
  logic [RW-1:0] s1_row;
  logic s1_valid, en, issue, fire, start_fire;
  logic [COLS_PER_ROW-1:0] pos, neg;
  assign en = !bus.out_valid || bus.out_ready;
  assign issue = state == SCAN && en;
  assign fire = bus.out_valid && bus.out_ready;
  assign bus.load_ready = state == IDLE;
  assign bus.start_ready = state == IDLE;
  assign start_fire = bus.start_ready && bus.start_valid;
  literal_row_matcher #(.COLS_PER_ROW(COLS_PER_ROW), .LIT_WIDTH(LIT_WIDTH)) u_match (
    .row(s1_row), .t(t_q), .mode(mode_q), .pos_mask(pos), .neg_mask(neg)
  );
  always_comb begin
    state_nx = start_fire ? SCAN
             : (issue && cnt == LAST) ? DRAIN
             : (state == DRAIN && fire && bus.out_last) ? IDLE
             : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_ROWS; r++) rows[r] <= '0;
      t_q <= '0;
      mode_q <= EXACT;
      cnt <= '0;
      s1_valid <= 1'b0;
      s1_row <= '0;
      s1_idx <= '0;
      bus.out_valid <= 1'b0;
      bus.out_pos_mask <= '0;
      bus.out_neg_mask <= '0;
      bus.out_row_idx <= '0;
      bus.out_last <= 1'b0;
      bus.done <= 1'b0;
      bus.match_count <= '0;
    end else begin
      bus.done <= state == DRAIN && fire && bus.out_last;
      if (bus.load_ready && bus.load_valid) rows[bus.load_addr] <= bus.load_row;
      if (start_fire) begin
        t_q <= bus.start_literal;
        mode_q <= bus.start_mode == 2'd3 ? EITHER : scan_mode_e'(bus.start_mode);
        cnt <= '0;
      end else if (issue && cnt != LAST) cnt <= cnt + ROW_W'(1);
      if (start_fire) bus.match_count <= '0;
      else if (fire && |(bus.out_pos_mask | bus.out_neg_mask)) bus.match_count <= bus.match_count + (ROW_W+1)'(1);
      // every pipeline stage freezes together under backpressure
      if (en) begin
        s1_valid <= issue;
        s1_row <= rows[cnt];
        s1_idx <= cnt;
        bus.out_valid <= s1_valid;
        bus.out_pos_mask <= s1_valid ? pos : '0;
        bus.out_neg_mask <= s1_valid ? neg : '0;
        bus.out_row_idx <= s1_idx;
        bus.out_last <= s1_valid && s1_idx == LAST;
      end
    end
  end
endmodule

// File: doc/clause_row_scanner.md
# clause_row_scanner

Sequential, parametrised successor to the single-row literal comparator for the SAT clause datapath. It holds a NUM_ROWS-deep store of clause rows and, on a start handshake, streams one row per cycle through a two-stage pipeline. Each row produces separate positive and complement match masks under a selectable polarity mode, with output backpressure, per-scan match counting and a completion pulse. It sits between the clause loader and the watch/propagation logic.

## Interface
- COLS_PER_ROW, 4, literal slots per row
- LIT_WIDTH, 6, literal width; bit 0 is polarity (1 = negated), bits [LIT_WIDTH-1:1] are the variable index
- NUM_ROWS, 16, rows in the store (≥2)
- ROW_W, $clog2(NUM_ROWS), row index width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  write request to the row store
- load_ready  out  1  high only in IDLE
- load_addr  in  ROW_W  row to write
- load_row  in  COLS_PER_ROW*LIT_WIDTH  row data; slot i is [i*LIT_WIDTH +: LIT_WIDTH]
- start_valid / start_ready  in / out  1  scan request handshake; start_ready is high only in IDLE
- start_literal  in  LIT_WIDTH  target literal T
- start_mode  in  2  0 = exact, 1 = complement, 2 = either, 3 = treated as 2
- out_valid / out_ready  out / in  1  result handshake
- out_row_idx  out  ROW_W  row index of the result
- out_pos_mask  out  COLS_PER_ROW  slot == T (mode 0 or 2)
- out_neg_mask  out  COLS_PER_ROW  slot == T^1 (mode 1 or 2)
- out_last  out  1  result is for row NUM_ROWS-1
- done  out  1  one-cycle pulse at scan end
- match_count  out  ROW_W+1  rows with any mask bit set in the last scan

## Operation
- Empty or invalid literal: variable index 0 (values 0 and 1). Such a slot never matches. A target with variable index 0 yields all-zero masks and is still scanned.
- Masks for disabled polarities are 0. In mode 2, a slot sets at most one of pos/neg.
- The FSM has three states: IDLE, SCAN and DRAIN.
- IDLE: a load is committed when load_valid. A start is accepted when start_valid. Accepting a start latches T and mode, clears match_count, sets the issue counter to 0 and moves to SCAN. If load_valid and start_valid are both high, the load commits first and the scan sees the new data.
- SCAN: issues row index cnt into stage 1 each enabled cycle. After issuing NUM_ROWS-1 it moves to DRAIN. The issue counter does not wrap.
- DRAIN: waits for the out_last handshake, then returns to IDLE. done is asserted in the cycle after that handshake.
- Pipeline enable: en = !out_valid || out_ready. When en=0, every stage, the issue counter and the FSM hold.
- Stage 1 registers the row data, the index and a valid bit. The output stage registers the masks, index, last and out_valid.
- match_count increments on each output handshake with (pos|neg) != 0. It holds its value after done until the next accepted start.
- Loads while not in IDLE are not accepted (load_ready=0). Row contents are stable during a scan.

## Timing
- Start accepted at edge T0. Row 0 becomes out_valid after edge T0+2. With out_ready held high, row k is presented in cycle T0+2+k. The last handshake is in cycle T0+1+NUM_ROWS, and done is asserted in the cycle after it.
- Outputs are held stable while out_valid && !out_ready.
- Reset values: state IDLE, out_valid 0, masks 0, out_row_idx 0, out_last 0, done 0, match_count 0, all rows 0 (empty). load_ready and start_ready go high in the first cycle after reset.
- rst mid-scan: the scan is aborted, the pipeline is flushed and no done is generated. rst takes priority over every handshake in the same cycle.

## Structure
- The shared package clause_pkg holds:
  - LIT_WIDTH default;
  - the scan_mode_e enum (EXACT, COMPL, EITHER);
  - the lit_compl function (L^1);
  - the lit_is_empty function (var index == 0).
- Sub-module literal_row_matcher is combinational: it takes row, T and mode and produces pos_mask and neg_mask. It is instantiated once in the output stage.
- The row store is a register array, to allow reset clearing and single-cycle reads.

## Test plan
- Exact-mode scan:
  - Stimulus: load row 3 = {0, 9, 8, 8} (slot3..slot0); start T=8, mode 0, out_ready=1.
  - Required response: row 3 gives pos=0011, neg=0000. All other rows give zero masks. match_count=1. done is asserted in cycle T0+2+NUM_ROWS.
- Complement and either modes on the same row:
  - Stimulus: row 3 as above; mode 1 with T=9, then mode 2 with T=9.
  - Required response: mode 1 gives neg=0011, pos=0. Mode 2 gives pos=0100, neg=0011.
- Empty literals:
  - Stimulus: T=1 with mode 2; separately T=0.
  - Required response: every row gives zero masks, even rows holding literal 0 or 1. match_count=0.
- Backpressure:
  - Stimulus: toggle out_ready randomly.
  - Required response: the row index sequence is 0..NUM_ROWS-1 with no gaps or duplicates. Outputs are stable while stalled. out_last appears exactly once.
- Blocked handshakes during a scan:
  - Stimulus: load_valid and start_valid asserted mid-scan.
  - Required response: load_ready=0 and start_ready=0. The store is unchanged.
- Reset mid-scan:
  - Stimulus: rst asserted after row 5.
  - Required response: out_valid=0 the next cycle, no done, and a subsequent scan sees all-zero rows.
